div_const_pipe: RTL and testbench

- Parametrised pipelined unsigned divider by a compile-time constant. Produces both quotient and remainder.
- Successor to the fixed 16-bit ÷3 registered quotient wrapper.
- Generalises width, divisor and pipeline depth, and adds valid/ready handshaking with backpressure, a synchronous flush and a remainder output.
- Sits between operand producers and the datapath consumers in the constant-division test harnesses.

---
 rtl/div_const_pipe_pkg.sv | 29 ++
 rtl/div_const_chunk.sv | 37 +++
 rtl/div_const_pipe.sv | 111 +++++++++++
 tb/tb_div_const_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_const_pipe_pkg.sv
// Shared helpers for the constant-divisor pipeline: width derivation and parameter legality.
package div_const_pkg;

    // Chunks at or below this width use a ROM instead of a divider.
    localparam int unsigned ROM_MAX_CW = 6;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned qw_f(input int unsigned width, input int unsigned divisor);
        return width - (clog2(divisor + 1) - 1);
    endfunction

    function automatic int unsigned rw_f(input int unsigned divisor);
        return clog2(divisor);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned divisor,
                                     input int unsigned stages);
        return (width >= 2) && (divisor >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/div_const_chunk.sv
// One long-division step: {r_in, c} / DIVISOR, split into quotient chunk and new remainder.
module div_const_chunk
    import div_const_pkg::*;
#(
    parameter int unsigned CW      = 8,
    parameter int unsigned DIVISOR = 3,
    localparam int unsigned RW     = rw_f(DIVISOR)
) (
    input  logic [RW-1:0] r_in,
    input  logic [CW-1:0] c,
    output logic [CW-1:0] q_chunk,
    output logic [RW-1:0] r_out
);

    localparam int unsigned AW = RW + CW;

    if (CW <= ROM_MAX_CW) begin : g_rom
        logic [CW-1:0] w_rom_q [2**AW];
        logic [RW-1:0] w_rom_r [2**AW];

        // Entries with r_in >= DIVISOR are unreachable; their truncation is harmless.
        for (genvar a = 0; a < 2**AW; a++) begin : g_ent
            assign w_rom_q[a] = CW'(a / DIVISOR);
            assign w_rom_r[a] = RW'(a % DIVISOR);
        end

        assign q_chunk = w_rom_q[{r_in, c}];
        assign r_out   = w_rom_r[{r_in, c}];
    end else begin : g_arith
        logic [AW-1:0] w_t;

        assign w_t     = {r_in, c};
        assign q_chunk = CW'(w_t / AW'(DIVISOR));
        assign r_out   = RW'(w_t % AW'(DIVISOR));
    end

endmodule

// File: rtl/div_const_pipe.sv
// Pipelined unsigned divide-by-constant with valid/ready flow control, flush and remainder.
module div_const_pipe
    import div_const_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIVISOR = 3,
    parameter int unsigned STAGES  = 2,
    localparam int unsigned CW     = WIDTH / STAGES,
    localparam int unsigned QW     = qw_f(WIDTH, DIVISOR),
    localparam int unsigned RW     = rw_f(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    out_q,
    output logic [RW-1:0]    out_r
);

    if (!params_ok(WIDTH, DIVISOR, STAGES)) begin : g_bad_params
        $error("div_const_pipe: illegal WIDTH/DIVISOR/STAGES combination");
    end

    // Each slot word holds {unprocessed dividend bits, quotient bits so far}, shifting left.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [RW-1:0]     r_rem  [STAGES];

    logic [WIDTH-1:0]  w_src_data [STAGES];
    logic [RW-1:0]     w_src_rem  [STAGES];
    logic [WIDTH-1:0]  w_nxt_data [STAGES];
    logic [RW-1:0]     w_nxt_rem  [STAGES];
    logic [CW-1:0]     w_qc       [STAGES];
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_src_data[s] = in_x;
            assign w_src_rem[s]  = '0;
        end else begin : g_rest
            assign w_src_data[s] = r_data[s-1];
            assign w_src_rem[s]  = r_rem[s-1];
        end

        div_const_chunk #(
            .CW      (CW),
            .DIVISOR (DIVISOR)
        ) u_chunk (
            .r_in    (w_src_rem[s]),
            .c       (w_src_data[s][WIDTH-1 -: CW]),
            .q_chunk (w_qc[s]),
            .r_out   (w_nxt_rem[s])
        );

        assign w_nxt_data[s] = (w_src_data[s] << CW) | WIDTH'(w_qc[s]);
    end

    // Ready ripples upstream from the output so bubbles compress.
    always_comb begin
        logic l_adv;
        w_adv         = '0;
        l_adv         = r_valid[STAGES-1] & out_ready;
        w_adv[STAGES-1] = l_adv;
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            l_adv    = r_valid[s] & (~r_valid[s+1] | l_adv);
            w_adv[s] = l_adv;
        end
    end

    assign in_ready = ~flush & (~r_valid[0] | w_adv[0]);

    always_comb begin
        w_load    = '0;
        w_load[0] = in_valid & in_ready;
        for (int s = 1; s < int'(STAGES); s++) begin
            w_load[s] = w_adv[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                r_data[s] <= '0;
                r_rem[s]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= 1'b1;
                    r_data[s]  <= w_nxt_data[s];
                    r_rem[s]   <= w_nxt_rem[s];
                end else if (w_adv[s]) begin
                    r_valid[s] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_q     = r_data[STAGES-1][QW-1:0];
    assign out_r     = r_rem[STAGES-1];

endmodule

// File: tb/tb_div_const_pipe.sv
// Bench for div_const_pipe: three configurations checked against an x/D, x%D scoreboard.
module tb_div_const_pipe;

    typedef struct {
        logic [15:0] x;
        int          q;
        int          r;
        int          t;
    } sb_t;

    typedef struct {
        logic [15:0] x;
        int          q;
        int          r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // ÷3, 2 stages
    logic        rst_a = 1'b0, fl_a = 1'b0, iv_a = 1'b0, ordy_a = 1'b1;
    logic        ir_a, ov_a;
    logic [15:0] xa = '0;
    logic [14:0] oq_a;
    logic [1:0]  orm_a;
    // ÷7, 4 stages
    logic        rst_b = 1'b0, fl_b = 1'b0, iv_b = 1'b0, ordy_b = 1'b1;
    logic        ir_b, ov_b;
    logic [15:0] xb = '0;
    logic [13:0] oq_b;
    logic [2:0]  orm_b;
    // ÷8, 1 stage
    logic        rst_c = 1'b0, fl_c = 1'b0, iv_c = 1'b0, ordy_c = 1'b1;
    logic        ir_c, ov_c;
    logic [15:0] xc = '0;
    logic [12:0] oq_c;
    logic [2:0]  orm_c;

    div_const_pipe #(.WIDTH(16), .DIVISOR(3), .STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a), .in_x(xa),
        .out_valid(ov_a), .out_ready(ordy_a), .out_q(oq_a), .out_r(orm_a)
    );
    div_const_pipe #(.WIDTH(16), .DIVISOR(7), .STAGES(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b), .in_x(xb),
        .out_valid(ov_b), .out_ready(ordy_b), .out_q(oq_b), .out_r(orm_b)
    );
    div_const_pipe #(.WIDTH(16), .DIVISOR(8), .STAGES(1)) u_dut_c (
        .clk(clk), .rst(rst_c), .flush(fl_c), .in_valid(iv_c), .in_ready(ir_c), .in_x(xc),
        .out_valid(ov_c), .out_ready(ordy_c), .out_q(oq_c), .out_r(orm_c)
    );

    sb_t qa[$];
    sb_t qb[$];
    sb_t qc[$];
    bit  lat_a = 0, lat_b = 0;
    int  n_acc_a = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor A: scoreboard pop, identity, range, latency and stall stability.
    logic        p_st_a = 1'b0;
    logic [14:0] p_q_a;
    logic [1:0]  p_r_a;
    always @(negedge clk) begin
        sb_t e;
        if (rst_a) begin
            qa.delete();
            p_st_a = 1'b0;
        end else begin
            if (p_st_a) begin
                chk("a_hold_valid", int'(ov_a), 1);
                chk("a_hold_q", int'(oq_a), int'(p_q_a));
                chk("a_hold_r", int'(orm_a), int'(p_r_a));
            end
            if (ov_a && ordy_a) begin
                chk("a_sb_nonempty", int'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_q", int'(oq_a), e.q);
                    chk("a_r", int'(orm_a), e.r);
                    chk("a_recon", int'(oq_a) * 3 + int'(orm_a), int'(e.x));
                    chk("a_r_lt_d", int'(orm_a < 2'd3), 1);
                    if (lat_a) chk("a_latency", cyc - e.t, 1);
                end
            end
            if (fl_a) qa.delete();
            p_st_a = ov_a && !ordy_a && !fl_a;
            p_q_a  = oq_a;
            p_r_a  = orm_a;
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst_b) begin
            qb.delete();
        end else if (ov_b && ordy_b) begin
            chk("b_sb_nonempty", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_q", int'(oq_b), e.q);
                chk("b_r", int'(orm_b), e.r);
                chk("b_recon", int'(oq_b) * 7 + int'(orm_b), int'(e.x));
                chk("b_r_lt_d", int'(orm_b < 3'd7), 1);
                if (lat_b) chk("b_latency", cyc - e.t, 3);
            end
        end
    end

    logic        p_st_c = 1'b0;
    logic [12:0] p_q_c;
    logic [2:0]  p_r_c;
    always @(negedge clk) begin
        sb_t e;
        if (rst_c) begin
            qc.delete();
            p_st_c = 1'b0;
        end else begin
            if (p_st_c) begin
                chk("c_hold_valid", int'(ov_c), 1);
                chk("c_hold_q", int'(oq_c), int'(p_q_c));
                chk("c_hold_r", int'(orm_c), int'(p_r_c));
            end
            if (ov_c && ordy_c) begin
                chk("c_sb_nonempty", int'(qc.size() > 0), 1);
                if (qc.size() > 0) begin
                    e = qc.pop_front();
                    chk("c_q", int'(oq_c), e.q);
                    chk("c_r", int'(orm_c), e.r);
                    chk("c_recon", int'(oq_c) * 8 + int'(orm_c), int'(e.x));
                end
            end
            if (iv_c && ir_c) qc.push_back('{xc, int'(xc) / 8, int'(xc) % 8, cyc + 1});
            p_st_c = ov_c && !ordy_c;
            p_q_c  = oq_c;
            p_r_c  = orm_c;
        end
    end

    // Present x, hold until accepted, record expectation; returns 1 ns after the accepting edge.
    task automatic send_a(input logic [15:0] x, input int q, input int r);
        int n = 0;
        iv_a = 1'b1;
        xa   = x;
        @(negedge clk);
        while (!ir_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_wait", int'(n < 200), 1);
        if (n < 200) begin
            qa.push_back('{x, q, r, cyc + 1});
            n_acc_a++;
        end
        @(posedge clk);
        #1 iv_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] x, input int q, input int r);
        int n = 0;
        iv_b = 1'b1;
        xb   = x;
        @(negedge clk);
        while (!ir_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_accept_wait", int'(n < 200), 1);
        if (n < 200) qb.push_back('{x, q, r, cyc + 1});
        @(posedge clk);
        #1 iv_b = 1'b0;
    endtask

    task automatic wait_empty(input int which);
        int n = 0;
        while (((which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size()) != 0
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size(), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t va[3];
    vec_t vb[2];
    int   acc_c = 0;
    int   lim   = 0;
    bit   took  = 0;

    initial begin
        va[0] = '{16'd100,   33,    1};
        va[1] = '{16'd65535, 21845, 0};
        va[2] = '{16'd0,     0,     0};
        vb[0] = '{16'd1000,  142,   6};
        vb[1] = '{16'd65535, 9362,  1};

        #2 rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", int'(ov_a), 0);
        chk("rst_a_q", int'(oq_a), 0);
        chk("rst_a_r", int'(orm_a), 0);
        chk("rst_a_ready", int'(ir_a), 1);
        chk("rst_b_valid", int'(ov_b), 0);
        chk("rst_b_q", int'(oq_b), 0);
        chk("rst_c_valid", int'(ov_c), 0);
        chk("rst_c_ready", int'(ir_c), 1);
        @(posedge clk);
        #1;

        // Back-to-back table vectors, no stall.
        lat_a = 1;
        for (int i = 0; i < 3; i++) send_a(va[i].x, va[i].q, va[i].r);
        wait_empty(0);
        lat_a = 0;

        // Ten-item stream against a five-cycle output stall.
        ordy_a  = 1'b0;
        n_acc_a = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_a(16'(i * 1237 + 11), (i * 1237 + 11) / 3, (i * 1237 + 11) % 3);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("a_accepts_at_stall", n_acc_a, 2);
                chk("a_ready_low_when_full", int'(ir_a), 0);
                @(posedge clk);
                #1 ordy_a = 1'b1;
            end
        join
        wait_empty(0);
        chk("a_stream_count", n_acc_a, 10);

        // Flush with two in flight and a simultaneous input.
        ordy_a = 1'b0;
        send_a(16'd200, 66, 2);
        send_a(16'd300, 100, 0);
        fl_a = 1'b1;
        iv_a = 1'b1;
        xa   = 16'd999;
        @(negedge clk);
        chk("a_flush_ready", int'(ir_a), 0);
        @(posedge clk);
        #1 fl_a = 1'b0; iv_a = 1'b0;
        @(negedge clk);
        chk("a_flush_valid", int'(ov_a), 0);
        @(posedge clk);
        #1 ordy_a = 1'b1;
        lat_a = 1;
        send_a(16'd500, 166, 2);
        wait_empty(0);
        lat_a = 0;

        // Asynchronous reset with a full pipeline.
        ordy_a = 1'b0;
        send_a(16'd1, 0, 1);
        send_a(16'd2, 0, 2);
        #3 rst_a = 1'b1;
        #1;
        chk("a_async_rst_valid", int'(ov_a), 0);
        chk("a_async_rst_q", int'(oq_a), 0);
        chk("a_async_rst_r", int'(orm_a), 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_a = 1'b0; ordy_a = 1'b1;
        send_a(16'd7, 2, 1);
        wait_empty(0);

        // Four-stage ÷7.
        lat_b = 1;
        for (int i = 0; i < 2; i++) send_b(vb[i].x, vb[i].q, vb[i].r);
        wait_empty(1);
        lat_b = 0;

        // Single-stage ÷8 random traffic with random backpressure.
        while (acc_c < 10000 && lim < 60000) begin
            if (!iv_c || took) begin
                iv_c = ($urandom_range(3) != 0);
                case ($urandom_range(15))
                    0:       xc = 16'h0000;
                    1:       xc = 16'hFFFF;
                    default: xc = 16'($urandom);
                endcase
            end
            ordy_c = ($urandom_range(3) != 0);
            @(negedge clk);
            took = iv_c && ir_c;
            if (took) acc_c++;
            lim++;
            @(posedge clk);
            #1;
        end
        iv_c   = 1'b0;
        ordy_c = 1'b1;
        chk("c_accepted", acc_c, 10000);
        wait_empty(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
